// File: rtl/rtc_pkg.sv
// Shared calendar definitions: mode encodings, month-length table and small helpers.
package rtc_pkg;

  typedef enum logic [2:0] {
    MODE_RUN       = 3'd0,
    MODE_SET_MIN   = 3'd1,
    MODE_SET_HOUR  = 3'd2,
    MODE_SET_DAY   = 3'd3,
    MODE_SET_MONTH = 3'd4
  } mode_e;

  // Fixed non-leap calendar, January first.
  localparam logic [4:0] MONTH_LEN [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  function automatic logic [4:0] month_len(input logic [3:0] month);
    logic [4:0] len;
    len = 5'd31;
    for (int i = 0; i < 12; i++) begin
      if (month == 4'(i + 1)) len = MONTH_LEN[i];
    end
    return len;
  endfunction

  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      MODE_RUN:       n = MODE_SET_MIN;
      MODE_SET_MIN:   n = MODE_SET_HOUR;
      MODE_SET_HOUR:  n = MODE_SET_DAY;
      MODE_SET_DAY:   n = MODE_SET_MONTH;
      default:        n = MODE_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Key debouncer: synchronises a raw key, samples it every DB_DIV clocks and accepts a
// new level after DB_LEN equal samples; press_o pulses once on an accepted rising level.
module key_debounce #(
  parameter int DB_DIV = 1024,
  parameter int DB_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_DIV - 1);

  logic [1:0]        sync_q;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DB_LEN-1:0] hist_q, hist_d;
  logic              level_q, level_d;
  logic              press_q;
  logic              sample;

  assign sample = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = sample ? '0 : cnt_q + 1'b1;
    hist_d  = hist_q;
    level_d = level_q;
    if (sample) begin
      hist_d = {hist_q[DB_LEN-2:0], sync_q[1]};
      if (&hist_d) begin
        level_d = 1'b1;
      end else if (~|hist_d) begin
        level_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      hist_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      hist_q  <= hist_d;
      level_q <= level_d;
      press_q <= level_d & ~level_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/rtc_calendar.sv
// Seconds-to-month real-time calendar with two-key setting interface (mode, increment).
// Time only advances in RUN; the set modes edit one field at a time without carry.
module rtc_calendar
  import rtc_pkg::*;
#(
  parameter int CLK_DIV = 65536,
  parameter int DB_DIV  = 1024,
  parameter int DB_LEN  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run_en,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic       sec_pulse,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hour,
  output logic [4:0] day,
  output logic [3:0] month,
  output logic [2:0] mode,
  output logic       setting
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic          mode_press, inc_press;
  mode_e         mode_q;
  logic          setting_q;
  logic          sec_pulse_q;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, min_q, min_d;
  logic [4:0]    hour_q, hour_d, day_q, day_d;
  logic [3:0]    month_q, month_d, month_inc;
  logic [4:0]    len_cur, len_inc;
  logic          tick;

  key_debounce #(.DB_DIV(DB_DIV), .DB_LEN(DB_LEN)) u_db_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_mode),
    .press_o (mode_press)
  );

  key_debounce #(.DB_DIV(DB_DIV), .DB_LEN(DB_LEN)) u_db_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_i   (key_inc),
    .press_o (inc_press)
  );

  assign month_inc = (month_q >= 4'd12) ? 4'd1 : month_q + 4'd1;
  assign len_cur   = month_len(month_q);
  assign len_inc   = month_len(month_inc);
  assign tick      = (mode_q == MODE_RUN) && run_en && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    day_d   = day_q;
    month_d = month_q;
    if (mode_q == MODE_RUN) begin
      if (run_en) presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
      // Full carry chain resolves in the tick cycle itself.
      if (tick) begin
        if (sec_q >= 6'd59) begin
          sec_d = 6'd0;
          if (min_q >= 6'd59) begin
            min_d = 6'd0;
            if (hour_q >= 5'd23) begin
              hour_d = 5'd0;
              if (day_q >= len_cur) begin
                day_d   = 5'd1;
                month_d = month_inc;
              end else begin
                day_d = day_q + 5'd1;
              end
            end else begin
              hour_d = hour_q + 5'd1;
            end
          end else begin
            min_d = min_q + 6'd1;
          end
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
      if (mode_press) begin
        sec_d   = 6'd0;
        presc_d = '0;
      end
    end else begin
      sec_d   = 6'd0;
      presc_d = '0;
      // A simultaneous mode press wins; the increment is dropped.
      if (inc_press && !mode_press) begin
        case (mode_q)
          MODE_SET_MIN:   min_d  = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
          MODE_SET_HOUR:  hour_d = (hour_q >= 5'd23) ? 5'd0 : hour_q + 5'd1;
          MODE_SET_DAY:   day_d  = (day_q >= len_cur) ? 5'd1 : day_q + 5'd1;
          MODE_SET_MONTH: begin
            month_d = month_inc;
            if (day_q > len_inc) day_d = len_inc;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      sec_q       <= 6'd0;
      min_q       <= 6'd0;
      hour_q      <= 5'd0;
      day_q       <= 5'd1;
      month_q     <= 4'd1;
      sec_pulse_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      sec_pulse_q <= tick;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_RUN;
      setting_q <= 1'b0;
    end else if (mode_press) begin
      mode_q    <= next_mode(mode_q);
      setting_q <= (next_mode(mode_q) != MODE_RUN);
    end
  end

  assign sec_pulse = sec_pulse_q;
  assign sec       = sec_q;
  assign min       = min_q;
  assign hour      = hour_q;
  assign day       = day_q;
  assign month     = month_q;
  assign mode      = mode_q;
  assign setting   = setting_q;

endmodule

// File: tb/tb_rtc_calendar.sv
// Directed bench for rtc_calendar with a fast prescaler and short debounce windows.
module tb_rtc_calendar;

  localparam int CLK_DIV = 4;
  localparam int DB_DIV  = 2;
  localparam int DB_LEN  = 3;
  localparam int HOLD    = (DB_LEN + 2) * DB_DIV;

  logic       clk;
  logic       rst_n;
  logic       run_en;
  logic       key_mode;
  logic       key_inc;
  logic       sec_pulse;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [4:0] day;
  logic [3:0] month;
  logic [2:0] mode;
  logic       setting;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt;
  logic [31:0] exp_q[$];

  rtc_calendar #(.CLK_DIV(CLK_DIV), .DB_DIV(DB_DIV), .DB_LEN(DB_LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run_en    (run_en),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .sec_pulse (sec_pulse),
    .sec       (sec),
    .min       (min),
    .hour      (hour),
    .day       (day),
    .month     (month),
    .mode      (mode),
    .setting   (setting)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] stamp(input logic [3:0] mo, input logic [4:0] d,
                                        input logic [4:0] h, input logic [5:0] mi,
                                        input logic [5:0] s);
    return {6'd0, mo, d, h, mi, s};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag);
    check_val(tag, stamp(month, day, hour, min, sec), exp_q.pop_front());
  endtask

  // driver tasks: all start and end at a falling edge
  task automatic press(input logic m, input logic i, input int n);
    for (int k = 0; k < n; k++) begin
      key_mode = m;
      key_inc  = i;
      repeat (HOLD) @(negedge clk);
      key_mode = 1'b0;
      key_inc  = 1'b0;
      repeat (HOLD) @(negedge clk);
    end
  endtask

  task automatic run_edges(input int n);
    run_en = 1'b1;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      if (sec_pulse) pulse_cnt++;
    end
    run_en = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    run_en   = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    pulse_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    exp_q.push_back(stamp(4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
    check_time("reset_time");
    check_val("reset_mode", mode, 0);
    check_val("reset_setting", setting, 0);
    check_val("reset_pulse", sec_pulse, 0);

    // one-sample glitch on the mode key is rejected
    key_mode = 1'b1;
    repeat (DB_DIV) @(negedge clk);
    key_mode = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_val("glitch_mode", mode, 0);

    // one minute of running
    run_edges(CLK_DIV * 60);
    check_val("run_pulses", pulse_cnt, 60);
    check_val("run_sec", sec, 0);
    check_val("run_min", min, 1);

    // run_en low holds time and prescaler
    repeat (20) @(negedge clk);
    check_val("hold_sec", sec, 0);
    run_edges(CLK_DIV - 1);
    check_val("partial_sec", sec, 0);
    repeat (10) @(negedge clk);
    run_edges(1);
    check_val("resume_sec", sec, 1);
    check_val("resume_pulse", sec_pulse, 1);

    // inc ignored in RUN
    press(1'b0, 1'b1, 1);
    check_val("run_inc_min", min, 1);
    check_val("run_inc_mode", mode, 0);

    // mode held exactly DB_LEN samples -> one advance, sec cleared
    key_mode = 1'b1;
    repeat (DB_LEN * DB_DIV) @(negedge clk);
    key_mode = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_val("setmin_mode", mode, 1);
    check_val("setmin_setting", setting, 1);
    check_val("setmin_sec", sec, 0);

    press(1'b0, 1'b1, 58);
    check_val("set_min59", min, 59);
    press(1'b1, 1'b0, 1);
    check_val("sethour_mode", mode, 2);
    press(1'b0, 1'b1, 23);
    check_val("set_hour23", hour, 23);
    press(1'b0, 1'b1, 1);
    check_val("hour_wrap", hour, 0);
    press(1'b0, 1'b1, 23);

    // simultaneous presses: mode wins
    press(1'b1, 1'b1, 1);
    check_val("both_mode", mode, 3);
    check_val("both_hour", hour, 23);

    press(1'b0, 1'b1, 30);
    check_val("set_day31", day, 31);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 1);
    check_val("clamp_month", month, 2);
    check_val("clamp_day", day, 28);
    press(1'b0, 1'b1, 10);
    check_val("set_month12", month, 12);
    check_val("dec_day", day, 28);
    press(1'b1, 1'b0, 1);
    check_val("back_run_mode", mode, 0);
    check_val("back_run_setting", setting, 0);

    press(1'b1, 1'b0, 3);
    check_val("dec_setday_mode", mode, 3);
    press(1'b0, 1'b1, 3);
    check_val("dec_day31", day, 31);
    press(1'b0, 1'b1, 1);
    check_val("day_wrap", day, 1);
    press(1'b0, 1'b1, 30);
    press(1'b1, 1'b0, 2);

    // Dec 31 23:59:00 -> year-end rollover
    pulse_cnt = 0;
    run_edges(CLK_DIV * 59);
    exp_q.push_back(stamp(4'd12, 5'd31, 5'd23, 6'd59, 6'd59));
    check_time("dec31_235959");
    run_edges(CLK_DIV);
    exp_q.push_back(stamp(4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
    check_time("jan1_000000");
    check_val("yearend_pulse", sec_pulse, 1);

    // Jan 31 23:59:00 -> Feb 1
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 59);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 23);
    press(1'b1, 1'b0, 1);
    press(1'b0, 1'b1, 30);
    press(1'b1, 1'b0, 2);
    check_val("jan_run_mode", mode, 0);
    run_edges(CLK_DIV * 59);
    exp_q.push_back(stamp(4'd1, 5'd31, 5'd23, 6'd59, 6'd59));
    check_time("jan31_235959");
    run_edges(CLK_DIV);
    exp_q.push_back(stamp(4'd2, 5'd1, 5'd0, 6'd0, 6'd0));
    check_time("feb1_000000");

    // reset mid-debounce while in a set mode
    press(1'b1, 1'b0, 1);
    check_val("pre_reset_mode", mode, 1);
    key_mode = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.push_back(stamp(4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
    check_time("async_reset_time");
    check_val("async_reset_mode", mode, 0);
    check_val("async_reset_setting", setting, 0);
    @(negedge clk);
    key_mode = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check_val("post_reset_mode", mode, 0);
    check_val("post_reset_pulse", sec_pulse, 0);
    exp_q.push_back(stamp(4'd1, 5'd1, 5'd0, 6'd0, 6'd0));
    check_time("post_reset_time");
    press(1'b1, 1'b0, 1);
    check_val("post_reset_press", mode, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rtc_calendar.md
RTC_CALENDAR -- requirements
Module: rtc_calendar

Interface
REQ-001 SHALL have parameter CLK_DIV, default 65536: clk cycles per second tick, minimum 2.
REQ-002 SHALL have parameter DB_DIV, default 1024: clk cycles between key samples, minimum 1.
REQ-003 SHALL have parameter DB_LEN, default 4: consecutive equal samples needed to accept a key level, range 2..8.
REQ-004 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port run_en  input  1  high lets time advance in RUN mode.
REQ-007 SHALL have port key_mode  input  1  raw, undebounced mode-select key, active high.
REQ-008 SHALL have port key_inc  input  1  raw, undebounced increment key, active high.
REQ-009 SHALL have port sec_pulse  output  1  one-cycle pulse on each accepted second tick.
REQ-010 SHALL have ports sec/min  output  6 each  0..59.
REQ-011 SHALL have ports hour  output  5  0..23; day  output  5  1..31; month  output  4  1..12.
REQ-012 SHALL have port mode  output  3  current mode encoding.
REQ-013 SHALL have port setting  output  1  high whenever mode is not RUN.

Function
REQ-014 SHALL run a prescaler counting 0..CLK_DIV-1 with wrap; a tick occurs when it equals CLK_DIV-1, mode is RUN and run_en is 1.
REQ-015 SHALL, with run_en low in RUN, hold the prescaler and all time fields.
REQ-016 SHALL, on a tick, assert sec_pulse the next cycle and advance sec; 59 wraps to 0 and carries to min in the same cycle.
REQ-017 SHALL cascade min 59->0 to hour, hour 23->0 to day, and day at month length ->1 to month, all in the same cycle.
REQ-018 SHALL wrap month 12->1 with no further carry.
REQ-019 SHALL use month lengths 31,28,31,30,31,30,31,31,30,31,30,31; there is no year and no leap day.
REQ-020 SHALL implement modes RUN=0, SET_MIN=1, SET_HOUR=2, SET_DAY=3, SET_MONTH=4.
REQ-021 SHALL advance mode on each mode press: RUN->SET_MIN->SET_HOUR->SET_DAY->SET_MONTH->RUN.
REQ-022 SHALL, on leaving RUN, clear sec and the prescaler; both stay 0 until RUN resumes.
REQ-023 SHALL, on an inc press, add 1 to the selected field with wraparound and no carry: min 59->0, hour 23->0, day at month length ->1, month 12->1.
REQ-024 SHALL ignore inc presses in RUN.
REQ-025 SHALL, when a month change leaves day above the new month length, clamp day to that length in the same cycle.
REQ-026 SHALL, on a cycle with both a mode press and an inc press, act only on the mode press.
REQ-027 SHALL debounce each key by sampling every DB_DIV clocks; the accepted level changes only after DB_LEN consecutive equal samples.
REQ-028 SHALL generate a press as a one-cycle pulse on the accepted level's 0->1 transition; holding a key produces one press.

Reset
REQ-029 SHALL, on rst_n low, immediately set: sec=0, min=0, hour=0, day=1, month=1, mode=RUN, setting=0, sec_pulse=0, prescaler=0, debounce counters/history=0, accepted key levels=0.
REQ-030 SHALL, when reset is asserted in the middle of a debounce window or set sequence, discard all partial state; no press is generated on release.

Structure
REQ-031 SHALL place mode encodings and the 12-entry month-length table in shared package rtc_pkg.
REQ-032 SHALL instantiate sub-module key_debounce, with DB_DIV and DB_LEN parameters, twice (mode key, inc key), sharing no sample counter.

Verification (CLK_DIV=4, DB_DIV=2, DB_LEN=3)
REQ-033 SHALL verify: reset, run_en=1 for 4*60 cycles -> sec returns to 0, min=1, 60 sec_pulse pulses seen.
REQ-034 SHALL verify: preload 23:59:59 on Jan 31, one tick -> 00:00:00 on Feb 1; from Dec 31 23:59:59 -> Jan 1.
REQ-035 SHALL verify: key_mode held high for 1 sample then low -> mode unchanged; held 3 samples -> exactly one advance to SET_MIN, sec=0.
REQ-036 SHALL verify: SET_DAY with day=31 on month 1, switch to SET_MONTH, one inc -> month=2, day=28.
REQ-037 SHALL verify: simultaneous accepted presses in SET_HOUR -> mode=SET_DAY, hour unchanged.
REQ-038 SHALL verify: rst_n asserted mid-debounce with key held -> no press after release, all outputs at reset values.
